// File: rtl/user_obi_sbr_mem_pkg.sv
// Shared widths and helpers for the OBI subordinate memory and its bus interface.
package user_obi_sbr_mem_pkg;

  // OBI bus widths used by the memory and its interface.
  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_ID_W   = 4;
  localparam int OBI_BE_W   = OBI_DATA_W / 8;

  // Merge a write word into an existing word, one byte lane per byte enable.
  function automatic logic [OBI_DATA_W-1:0] apply_be(
    input logic [OBI_DATA_W-1:0] old_word,
    input logic [OBI_DATA_W-1:0] wdata,
    input logic [OBI_BE_W-1:0]   be
  );
    logic [OBI_DATA_W-1:0] merged;
    merged = old_word;
    for (int k = 0; k < OBI_BE_W; k++) begin
      if (be[k]) begin
        merged[8*k +: 8] = wdata[8*k +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/user_obi_sbr_mem_if.sv
// OBI A-channel / R-channel bundle between a manager and the subordinate memory.
// There is no rready: the manager must accept a response in the cycle rvalid is high.
interface user_obi_sbr_mem_if
  import user_obi_sbr_mem_pkg::*;
#(
  parameter int AddrW = OBI_ADDR_W,
  parameter int DataW = OBI_DATA_W,
  parameter int IdW   = OBI_ID_W
) ();

  // A channel
  logic               req;
  logic               gnt;
  logic [AddrW-1:0]   addr;
  logic               we;
  logic [DataW/8-1:0] be;
  logic [DataW-1:0]   wdata;
  logic [IdW-1:0]     aid;

  // R channel
  logic               rvalid;
  logic [DataW-1:0]   rdata;
  logic [IdW-1:0]     rid;
  logic               err;
  logic               r_optional;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, rdata, rid, err, r_optional
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, rdata, rid, err, r_optional
  );

endinterface

// File: rtl/user_obi_rsp_queue.sv
// In-order response ring buffer. Each slot carries an age that starts at 1 in
// the cycle after the push and saturates at Latency; the head is "due" once
// its age reaches Latency. Payload storage is not reset, only the bookkeeping.
module user_obi_rsp_queue #(
  parameter int Depth   = 2,
  parameter int Latency = 1,
  parameter int EntryW  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  logic [EntryW-1:0] push_data,
  input  logic              pop,
  output logic [EntryW-1:0] head_data,
  output logic              due,
  output logic              full
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam int AgeW = $clog2(Latency + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
  localparam logic [AgeW-1:0] DueAge  = AgeW'(Latency);

  logic [EntryW-1:0] data_q [Depth];
  logic [AgeW-1:0]   age_q  [Depth];
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push_ok;
  logic              pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == FullCnt);
  assign due       = (count_q != '0) && (age_q[rd_ptr_q] == DueAge);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && due;
  assign head_data = data_q[rd_ptr_q];

  // Ring pointers and occupancy; simultaneous push and pop leave the count alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Per-slot age: a fresh push restarts at 1, otherwise count up to Latency and hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (push_ok && (wr_ptr_q == PtrW'(i))) begin
          age_q[i] <= AgeW'(1);
        end else if (age_q[i] != DueAge) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Response payload written at the tail slot.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      data_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/user_obi_sbr_mem.sv
// OBI subordinate backed by a flop-array word memory. Requests are granted
// while fewer than MaxOutstanding responses are pending; every handshake
// produces exactly one in-order response RspLatency cycles later. Addresses
// outside [BaseAddr, BaseAddr + 4*NumWords) return err=1 and touch nothing.
module user_obi_sbr_mem
  import user_obi_sbr_mem_pkg::*;
#(
  parameter logic [OBI_ADDR_W-1:0] BaseAddr       = '0,
  parameter int                    NumWords       = 64,
  parameter int                    RspLatency     = 1,
  parameter int                    MaxOutstanding = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  user_obi_sbr_mem_if.slave obi
);

  localparam int IdxW = $clog2(NumWords);
  localparam logic [OBI_ADDR_W:0] MemBytes = (OBI_ADDR_W + 1)'(NumWords) << 2;

  if (RspLatency < 1) begin : g_chk_latency
    $error("user_obi_sbr_mem: RspLatency must be at least 1");
  end
  if (MaxOutstanding < 1) begin : g_chk_outstanding
    $error("user_obi_sbr_mem: MaxOutstanding must be at least 1");
  end
  if ((NumWords < 2) || ((NumWords & (NumWords - 1)) != 0)) begin : g_chk_words
    $error("user_obi_sbr_mem: NumWords must be a power of two, at least 2");
  end

  typedef struct packed {
    logic [OBI_DATA_W-1:0] rdata;
    logic [OBI_ID_W-1:0]   rid;
    logic                  err;
  } rsp_entry_t;

  logic                  ready_q;
  logic                  hs;
  logic [OBI_ADDR_W-1:0] off;
  logic                  in_range;
  logic [IdxW-1:0]       idx;
  logic [OBI_DATA_W-1:0] mem_q [NumWords];
  rsp_entry_t            push_entry;
  rsp_entry_t            head_entry;
  logic                  q_full;
  logic                  q_due;

  // Grant is held low until the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Grant depends only on registered state, never on req.
  assign obi.gnt = ready_q && !q_full;
  assign hs      = obi.req && obi.gnt;

  // Address decode: addresses below BaseAddr wrap to a large offset and miss.
  assign off      = obi.addr - BaseAddr;
  assign in_range = ({1'b0, off} < MemBytes);
  assign idx      = off[2 +: IdxW];

  // Word memory: byte-enabled writes for in-range write handshakes only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else if (hs && obi.we && in_range) begin
      mem_q[idx] <= apply_be(mem_q[idx], obi.wdata, obi.be);
    end
  end

  // Response captured at handshake; read data reflects memory before this cycle's write.
  always_comb begin
    push_entry.rdata = '0;
    push_entry.rid   = obi.aid;
    push_entry.err   = !in_range;
    if (in_range && !obi.we) begin
      push_entry.rdata = mem_q[idx];
    end
  end

  user_obi_rsp_queue #(
    .Depth   (MaxOutstanding),
    .Latency (RspLatency),
    .EntryW  ($bits(rsp_entry_t))
  ) u_rsp_queue (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (hs),
    .push_data (push_entry),
    .pop       (q_due),
    .head_data (head_entry),
    .due       (q_due),
    .full      (q_full)
  );

  // No rready: a due head is presented and consumed in the same cycle.
  assign obi.rvalid     = q_due;
  assign obi.rdata      = q_due ? head_entry.rdata : '0;
  assign obi.rid        = q_due ? head_entry.rid : '0;
  assign obi.err        = q_due ? head_entry.err : 1'b0;
  assign obi.r_optional = 1'b0;

endmodule

// File: tb/tb_user_obi_sbr_mem.sv
// Bench for user_obi_sbr_mem: two instances (latency 1 and latency 4, both
// with two outstanding) share clock and reset. A transaction-level model
// (word array plus a list of expected responses with due cycles) predicts
// gnt, rvalid and response contents every cycle.
module tb_user_obi_sbr_mem;
  import user_obi_sbr_mem_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          NW   = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  user_obi_sbr_mem_if bus0 ();
  user_obi_sbr_mem_if bus1 ();

  user_obi_sbr_mem #(
    .BaseAddr(BASE), .NumWords(NW), .RspLatency(1), .MaxOutstanding(2)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .obi(bus0)
  );

  user_obi_sbr_mem #(
    .BaseAddr(BASE), .NumWords(NW), .RspLatency(4), .MaxOutstanding(2)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .obi(bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_cyc    = 0;

  // Reference model state
  logic [31:0] ref_mem [2][NW];
  int          q_hd [2];
  int          q_tl [2];
  logic [31:0] q_rdata [2][16];
  logic [3:0]  q_rid [2][16];
  logic        q_err [2][16];
  int          q_due [2][16];
  bit          m_ready;
  bit          e_gnt [2];
  bit          e_rv [2];

  // Observed outputs of the current cycle
  logic        o_gnt [2];
  logic        o_rv [2];
  logic [31:0] o_rdata [2];
  logic [3:0]  o_rid [2];
  logic        o_err [2];
  logic        o_ropt [2];

  // Log of observed responses
  logic [3:0]  log_rid [2][64];
  int          log_cyc [2][64];
  int          log_n [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: got %h, want %h", tag, d, obs, exp);
    end
  endtask

  task automatic sample();
    o_gnt[0] = bus0.gnt;   o_gnt[1] = bus1.gnt;
    o_rv[0] = bus0.rvalid; o_rv[1] = bus1.rvalid;
    o_rdata[0] = bus0.rdata; o_rdata[1] = bus1.rdata;
    o_rid[0] = bus0.rid;   o_rid[1] = bus1.rid;
    o_err[0] = bus0.err;   o_err[1] = bus1.err;
    o_ropt[0] = bus0.r_optional; o_ropt[1] = bus1.r_optional;
  endtask

  task automatic model_check(input int d);
    int sz;
    int h;
    sz = q_tl[d] - q_hd[d];
    h  = q_hd[d] % 16;
    e_gnt[d] = m_ready && (sz < 2);
    e_rv[d]  = (sz > 0) && (q_due[d][h] == cyc);
    chk("gnt", d, o_gnt[d], e_gnt[d]);
    chk("rvalid", d, o_rv[d], e_rv[d]);
    if (e_rv[d]) begin
      chk("rdata", d, o_rdata[d], q_rdata[d][h]);
      chk("rid", d, o_rid[d], q_rid[d][h]);
      chk("err", d, o_err[d], q_err[d][h]);
    end
    if ((o_rv[d] === 1'b1) && (log_n[d] < 64)) begin
      log_rid[d][log_n[d]] = o_rid[d];
      log_cyc[d][log_n[d]] = cyc;
      log_n[d]++;
    end
  endtask

  task automatic model_update(input int d, input bit req, input logic [31:0] addr, input bit we,
                              input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
    logic [31:0] off;
    logic [31:0] mask;
    bit          inr;
    int          idx;
    int          t;
    if (e_rv[d]) q_hd[d]++;
    if (req && e_gnt[d]) begin
      off = addr - BASE;
      inr = (off < 4 * NW);
      idx = inr ? int'(off) / 4 : 0;
      t   = q_tl[d] % 16;
      q_rdata[d][t] = (inr && !we) ? ref_mem[d][idx] : 32'h0;
      q_rid[d][t]   = aid;
      q_err[d][t]   = !inr;
      q_due[d][t]   = cyc + lat_of(d);
      q_tl[d]++;
      if (inr && we) begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        ref_mem[d][idx] = (ref_mem[d][idx] & ~mask) | (wdata & mask);
      end
    end
  endtask

  // One clock cycle: check outputs, then present the inputs for this cycle.
  task automatic step(input bit [1:0] mask, input logic [31:0] addr, input bit we,
                      input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
    @(negedge clk);
    sample();
    s_cyc = cyc;
    model_check(0);
    model_check(1);
    bus0.req = mask[0]; bus1.req = mask[1];
    bus0.addr = addr; bus1.addr = addr;
    bus0.we = we; bus1.we = we;
    bus0.be = be; bus1.be = be;
    bus0.wdata = wdata; bus1.wdata = wdata;
    bus0.aid = aid; bus1.aid = aid;
    model_update(0, mask[0], addr, we, be, wdata, aid);
    model_update(1, mask[1], addr, we, be, wdata, aid);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic set_reset(input bit v);
    rst_n = v;
    if (!v) begin
      m_ready = 1'b0;
      for (int d = 0; d < 2; d++) begin
        q_hd[d] = 0;
        q_tl[d] = 0;
        for (int i = 0; i < NW; i++) ref_mem[d][i] = 32'h0;
      end
    end else begin
      m_ready = 1'b1;
    end
  endtask

  // Hold a request on one bus until that DUT grants it.
  task automatic issue(input int d, input logic [31:0] addr, input bit we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [3:0] aid, output int hs);
    bit done;
    done = 1'b0;
    hs   = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      step(2'(1 << d), addr, we, be, wdata, aid);
      if (o_gnt[d] === 1'b1) begin
        done = 1'b1;
        hs   = s_cyc;
      end
    end
    if (!done) chk("issue_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int d, input int hs, output logic [31:0] rdata,
                          output logic [3:0] rid, output logic err, output int lat);
    bit got;
    got = 1'b0;
    rdata = 'x; rid = 'x; err = 1'bx; lat = -1;
    for (int i = 0; i < 12 && !got; i++) begin
      idle(1);
      if (o_rv[d] === 1'b1) begin
        got   = 1'b1;
        rdata = o_rdata[d];
        rid   = o_rid[d];
        err   = o_err[d];
        lat   = s_cyc - hs;
      end
    end
    if (!got) chk("rsp_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic xact(input int d, input logic [31:0] addr, input bit we, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [3:0] aid, output logic [31:0] rdata,
                      output logic [3:0] rid, output logic err, output int lat);
    int hs;
    issue(d, addr, we, be, wdata, aid, hs);
    wait_rsp(d, hs, rdata, rid, err, lat);
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  rid;
    logic        err;
    int          lat;
    int          hs_a [8];
    logic [31:0] addr;
    int          r;

    bus0.req = 1'b0; bus0.addr = '0; bus0.we = 1'b0; bus0.be = '0; bus0.wdata = '0; bus0.aid = '0;
    bus1.req = 1'b0; bus1.addr = '0; bus1.we = 1'b0; bus1.be = '0; bus1.wdata = '0; bus1.aid = '0;
    for (int d = 0; d < 2; d++) begin
      log_n[d] = 0;
      q_hd[d] = 0;
      q_tl[d] = 0;
      for (int i = 0; i < NW; i++) ref_mem[d][i] = 32'h0;
    end
    m_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    set_reset(1'b0);

    // Reset: gnt and rvalid low, response fields zero
    idle(3);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata", d, o_rdata[d], 32'h0);
      chk("rst_rid", d, o_rid[d], 32'h0);
      chk("rst_err", d, o_err[d], 32'h0);
      chk("rst_ropt", d, o_ropt[d], 32'h0);
    end
    set_reset(1'b1);
    idle(4);

    // Directed accesses on both latencies
    for (int d = 0; d < 2; d++) begin
      xact(d, BASE + 32'd20, 1'b0, 4'h0, 32'h0, 4'd3, rd, rid, err, lat);
      chk("rd5_rdata", d, rd, 32'h0);
      chk("rd5_err", d, err, 32'h0);
      chk("rd5_rid", d, rid, 32'd3);
      chk("rd5_lat", d, lat, lat_of(d));

      xact(d, BASE + 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 4'd1, rd, rid, err, lat);
      chk("wr_rdata", d, rd, 32'h0);
      chk("wr_err", d, err, 32'h0);
      xact(d, BASE + 32'h10, 1'b1, 4'b0001, 32'h000000AA, 4'd2, rd, rid, err, lat);
      xact(d, BASE + 32'h10, 1'b0, 4'h0, 32'h0, 4'd4, rd, rid, err, lat);
      chk("be_merge", d, rd, 32'hDEADBEAA);
      chk("be_lat", d, lat, lat_of(d));
      chk("be_rid", d, rid, 32'd4);
      xact(d, BASE + 32'h13, 1'b0, 4'h0, 32'h0, 4'd5, rd, rid, err, lat);
      chk("lowbits_ignored", d, rd, 32'hDEADBEAA);

      xact(d, BASE + 4 * NW, 1'b0, 4'h0, 32'h0, 4'd6, rd, rid, err, lat);
      chk("oor_rd_err", d, err, 32'h1);
      chk("oor_rd_rdata", d, rd, 32'h0);
      xact(d, BASE + 4 * NW, 1'b1, 4'hF, 32'hFFFFFFFF, 4'd7, rd, rid, err, lat);
      chk("oor_wr_err", d, err, 32'h1);
      xact(d, BASE, 1'b0, 4'h0, 32'h0, 4'd8, rd, rid, err, lat);
      chk("oor_no_alias", d, rd, 32'h0);
      chk("oor_no_alias_err", d, err, 32'h0);
      xact(d, BASE - 32'd4, 1'b0, 4'h0, 32'h0, 4'd9, rd, rid, err, lat);
      chk("below_base_err", d, err, 32'h1);
      xact(d, BASE + 4 * NW - 4, 1'b0, 4'h0, 32'h0, 4'd10, rd, rid, err, lat);
      chk("top_word_err", d, err, 32'h0);
    end

    // Throughput on the latency-1 instance: 8 back-to-back reads
    idle(6);
    log_n[0] = 0;
    for (int i = 0; i < 8; i++) issue(0, BASE + 32'(4 * i), 1'b0, 4'h0, 32'h0, 4'(i), hs_a[i]);
    idle(3);
    chk("tp_span", 0, hs_a[7] - hs_a[0], 32'd7);
    chk("tp_count", 0, log_n[0], 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("tp_rid", 0, log_rid[0][i], 32'(i));
      chk("tp_consecutive", 0, log_cyc[0][i] - log_cyc[0][0], 32'(i));
    end

    // Backpressure on the latency-4 instance: continuous requests
    idle(6);
    log_n[1] = 0;
    for (int i = 0; i < 4; i++) issue(1, BASE + 32'(4 * i), 1'b0, 4'h0, 32'h0, 4'(8 + i), hs_a[i]);
    idle(8);
    chk("bp_hs1", 1, hs_a[1] - hs_a[0], 32'd1);
    chk("bp_hs2", 1, hs_a[2] - hs_a[0], 32'd5);
    chk("bp_hs3", 1, hs_a[3] - hs_a[0], 32'd6);
    chk("bp_count", 1, log_n[1], 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_rid", 1, log_rid[1][i], 32'(8 + i));

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) addr = BASE - 32'($urandom_range(1, 8));
      else if (r == 1) addr = BASE + 32'(4 * NW) + 32'($urandom_range(0, 15));
      else if (r < 6) addr = BASE + 32'($urandom_range(0, 31));
      else addr = BASE + 32'($urandom_range(0, 4 * NW - 1));
      step(2'($urandom_range(0, 3)), addr, 1'($urandom_range(0, 1)), 4'($urandom),
           $urandom, 4'($urandom));
    end
    idle(6);

    // Reset with two responses outstanding on the latency-4 instance
    issue(1, BASE + 32'h10, 1'b0, 4'h0, 32'h0, 4'd1, hs_a[0]);
    issue(1, BASE + 32'h14, 1'b0, 4'h0, 32'h0, 4'd2, hs_a[1]);
    set_reset(1'b0);
    log_n[0] = 0;
    log_n[1] = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("midrst_gnt", 1, o_gnt[1], 32'h0);
      chk("midrst_rvalid", 1, o_rv[1], 32'h0);
    end
    set_reset(1'b1);
    idle(8);
    chk("no_stale_rsp", 0, log_n[0], 32'd0);
    chk("no_stale_rsp", 1, log_n[1], 32'd0);
    for (int d = 0; d < 2; d++) begin
      xact(d, BASE + 32'h10, 1'b0, 4'h0, 32'h0, 4'd12, rd, rid, err, lat);
      chk("mem_cleared", d, rd, 32'h0);
      chk("mem_cleared_rid", d, rid, 32'd12);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
